// File: rtl/adder_share_arb.sv
// adder_share_arb: one N-bit adder shared round-robin by NREQ requesters, result held in one registered slot.
// Define ADDER_SHARE_ARB_SAT_EN to saturate overflowing sums to all ones instead of wrapping.
module adder_share_arb #(
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_x1,
    input  logic [NREQ*N-1:0]       req_x2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [N-1:0]            rsp_y,
    output logic [$clog2(NREQ)-1:0] rsp_id
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, gnt_id;
    logic [N-1:0]   y_q, y_d, x1, x2;
    logic           free, found, xfer;
    int             idx;

    assign free = (state_q == EMPTY) | (rsp_ready & rsp_valid);

    // Scan rotated offsets high to low so the offset closest to ptr wins.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx[IDW-1:0];
            end
        end
    end

    assign req_ready = (found & free & rst_n) ? (NREQ'(1) << gnt_id) : '0;
    assign xfer      = |req_ready;
    assign x1        = req_x1[gnt_id*N +: N];
    assign x2        = req_x2[gnt_id*N +: N];

`ifdef ADDER_SHARE_ARB_SAT_EN
    logic [N:0] sum;
    assign sum = {1'b0, x1} + {1'b0, x2};
    assign y_d = sum[N] ? '1 : sum[N-1:0];
`else
    assign y_d = x1 + x2;
`endif

    assign ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    assign state_d = xfer ? FULL : (rsp_ready ? EMPTY : state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            y_q     <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                ptr_q <= ptr_d;
                y_q   <= y_d;
                id_q  <= gnt_id;
            end
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_y     = y_q;
    assign rsp_id    = id_q;
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed and random stimulus against a transaction-level model of the shared adder.
module tb_adder_share_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready, sticky;
    logic [63:0] req_x1, req_x2;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_y;
    logic [1:0]  rsp_id;

    int n_chk = 0, n_pass = 0;
    int m_ptr, g_obs;
    bit m_full;
    logic [15:0] m_y;
    int m_id;

    adder_share_arb #(.N(16), .NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] exp_sum(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef ADDER_SHARE_ARB_SAT_EN
        if (s > 65535) return 16'hFFFF;
`endif
        return 16'(s % 65536);
    endfunction

    function automatic int model_gnt();
        if (!rst_n || (m_full && !rsp_ready)) return -1;
        for (int k = 0; k < 4; k++)
            if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i] = 1'b1;
        req_x1[i*16 +: 16] = a;
        req_x2[i*16 +: 16] = b;
    endtask

    // Called at posedge+1; checks mid-cycle, advances one edge, returns at posedge+1.
    task automatic step();
        int g;
        logic [3:0] ev;
        #3;
        g  = model_gnt();
        ev = (g < 0) ? 4'b0 : 4'(1 << g);
        chk("req_ready", 32'(req_ready), 32'(ev));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            chk("rsp_y", 32'(rsp_y), 32'(m_y));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        g_obs = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) g_obs = i;
        @(posedge clk);
        if (g >= 0) begin
            m_y    = exp_sum(req_x1[g*16 +: 16], req_x2[g*16 +: 16]);
            m_id   = g;
            m_full = 1'b1;
            m_ptr  = (g + 1) % 4;
        end else if (rsp_ready) m_full = 1'b0;
        #1;
        if (g >= 0 && !sticky[g]) req_valid[g] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        sticky = '0;
        m_full = 1'b0;
        m_ptr = 0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_y", 32'(rsp_y), 0);
        chk("rst_id", 32'(rsp_id), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'hF;
        sticky = '0;
        req_x1 = '0;
        req_x2 = '0;
        rsp_ready = 1'b1;
        m_full = 1'b0;
        m_ptr = 0;
        m_y = '0;
        m_id = 0;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        do_reset();

        set_req(0, 16'h0003, 16'h0004);
        step();
        chk("single_gnt", 32'(g_obs), 0);
        chk("single_y", 32'(rsp_y), 32'h0007);
        step();
        chk("single_drain", 32'(rsp_valid), 0);

        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 16'(i), 16'(i));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("all4_valid", 32'(rsp_valid), 1);
            chk("all4_id", 32'(rsp_id), 32'(i));
            chk("all4_y", 32'(rsp_y), 32'(2 * i));
        end
        step();

        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 16'(10 * i), 16'h0100);
        rsp_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_id", 32'(rsp_id), 0);
            chk("bp_y", 32'(rsp_y), 32'h0100);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_regrant", 32'(g_obs), 1);
        for (int c = 0; c < 3; c++) step();

        do_reset();
        sticky = 4'b0101;
        set_req(0, 16'h0011, 16'h0022);
        step();
        step();
        set_req(2, 16'h1000, 16'h2000);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("fair_gnt", 32'(g_obs), (c % 2 == 0) ? 2 : 0);
        end
        sticky = '0;
        req_valid = '0;
        step();

        do_reset();
        set_req(0, 16'hFFFF, 16'h0002);
        step();
`ifdef ADDER_SHARE_ARB_SAT_EN
        chk("ovf", 32'(rsp_y), 32'hFFFF);
`else
        chk("ovf", 32'(rsp_y), 32'h0001);
`endif
        set_req(1, 16'h7FFF, 16'h0001);
        step();
        chk("no_ovf", 32'(rsp_y), 32'h8000);
        step();

        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 16'(i), 16'h0005);
        step();
        step();
        rsp_ready = 1'b0;
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(rsp_valid), 0);
        chk("async_ready", 32'(req_ready), 0);
        m_full = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 4; i++) set_req(i, 16'(i), 16'h0005);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        chk("post_rst_gnt", 32'(g_obs), 0);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++)
                if (!req_valid[i] && $urandom_range(2) == 0)
                    set_req(i, ($urandom_range(3) == 0) ? 16'hFFFF - 16'($urandom_range(3)) : 16'($urandom),
                            16'($urandom));
            rsp_ready = ($urandom_range(9) < 7);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
